// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// default bundle widths and the holding-state encoding of the skid variant.
package pipe_stage_reg_pkg;

   // Architectural widths of the carried bundles
   localparam int unsigned XLEN         = 32;
   localparam int unsigned REG_ADDR_W   = 5;
   localparam int unsigned STAGE_PC_W   = XLEN;
   // Data bundle: two operands, ALU result and destination register address
   localparam int unsigned STAGE_DATA_W = 3 * XLEN + REG_ADDR_W;

   // Control bundle width shared by all stage boundaries (write enables, selects)
   localparam int unsigned CTRL_W_STAGE = 3;

   // Default width of the stall performance counter
   localparam int unsigned STALL_CNT_W  = 16;

   // Occupancy of the two-entry variant
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_FULL  = 2'b01,
      ST_SKID  = 2'b10
   } skid_state_e;

endpackage : pipe_stage_reg_pkg

// File: rtl/pipe_skid_entry.sv
// One valid + payload register slice. "load" captures din and marks the slice
// valid; "drop" invalidates it and wins over load. Payload is only cleared by rst.
module pipe_skid_entry
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         drop,
   input  logic [W-1:0] din,
   output logic         valid,
   output logic [W-1:0] dout
);

   logic         valid_d, valid_q;
   logic [W-1:0] data_d,  data_q;

   // Next-state: load sets valid and captures payload, drop clears valid only
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = din;
      end
      if (drop) begin
         valid_d = 1'b0;
      end
   end

   // Slice registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign dout  = data_q;

endmodule : pipe_skid_entry

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, synchronous
// flush, optional two-entry skid buffer and a saturating stall counter.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int unsigned PC_W   = STAGE_PC_W,
   parameter int unsigned CTRL_W = CTRL_W_STAGE,
   parameter int unsigned DATA_W = STAGE_DATA_W,
   parameter int unsigned SKID   = 1,
   parameter int unsigned CNT_W  = STALL_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int unsigned PW = PC_W + CTRL_W + DATA_W;

   logic [PW-1:0]     in_payload;
   logic [PW-1:0]     main_din;
   logic [PW-1:0]     main_q;
   logic              main_load;
   logic              main_drop;
   logic              main_valid;
   logic [CTRL_W-1:0] main_ctrl;

   assign in_payload = {in_pc, in_ctrl, in_data};

   // Output-side entry; always present
   pipe_skid_entry #(.W(PW)) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_load),
      .drop  (main_drop),
      .din   (main_din),
      .valid (main_valid),
      .dout  (main_q)
   );

   assign out_valid = main_valid;
   assign out_pc    = main_q[PW-1 -: PC_W];
   assign main_ctrl = main_q[DATA_W +: CTRL_W];
   assign out_data  = main_q[DATA_W-1:0];
   // A bubble must never present an asserted write enable downstream
   assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};

   generate
      if (SKID == 0) begin : g_single

         assign in_ready = out_ready | ~main_valid;

         // Single slice: refill on input transfer, empty on unmatched output transfer
         always_comb begin
            main_din  = in_payload;
            main_load = in_valid & in_ready & ~flush;
            main_drop = flush | (main_valid & out_ready & ~(in_valid & in_ready));
         end

      end else begin : g_skid

         skid_state_e   state_d, state_q;
         logic          in_ready_d, in_ready_q;
         logic          skid_load;
         logic          skid_drop;
         logic          skid_valid;
         logic [PW-1:0] skid_q;

         // Overflow slice that catches the entry accepted while downstream stalls
         pipe_skid_entry #(.W(PW)) u_skid (
            .clk   (clk),
            .rst   (rst),
            .load  (skid_load),
            .drop  (skid_drop),
            .din   (in_payload),
            .valid (skid_valid),
            .dout  (skid_q)
         );

         // Occupancy transitions and slice load/drop strobes
         always_comb begin
            state_d   = state_q;
            main_load = 1'b0;
            main_drop = flush;
            skid_load = 1'b0;
            skid_drop = flush;
            // Skid contents always drain into main ahead of new input
            main_din  = skid_valid ? skid_q : in_payload;
            if (flush) begin
               state_d = ST_EMPTY;
            end else begin
               case (state_q)
                  ST_EMPTY: begin
                     if (in_valid) begin
                        main_load = 1'b1;
                        state_d   = ST_FULL;
                     end
                  end
                  ST_FULL: begin
                     if (out_ready) begin
                        if (in_valid) begin
                           main_load = 1'b1;
                        end else begin
                           main_drop = 1'b1;
                           state_d   = ST_EMPTY;
                        end
                     end else if (in_valid) begin
                        skid_load = 1'b1;
                        state_d   = ST_SKID;
                     end
                  end
                  ST_SKID: begin
                     if (out_ready) begin
                        main_load = 1'b1;
                        skid_drop = 1'b1;
                        state_d   = ST_FULL;
                     end
                  end
                  default: begin
                     main_drop = 1'b1;
                     skid_drop = 1'b1;
                     state_d   = ST_EMPTY;
                  end
               endcase
            end
            in_ready_d = (state_d != ST_SKID);
         end

         // Occupancy state and registered in_ready
         always_ff @(posedge clk) begin
            if (rst) begin
               state_q    <= ST_EMPTY;
               in_ready_q <= 1'b1;
            end else begin
               state_q    <= state_d;
               in_ready_q <= in_ready_d;
            end
         end

         assign in_ready = in_ready_q;

      end
   endgenerate

   logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

   // Saturating count of cycles where downstream holds off a valid entry
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_valid && !out_ready && !flush && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Stall counter register, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule : pipe_stage_reg
